// File: rtl/uart_pkg.sv
// UART shared types and constants.
// Used by the receiver and its sibling UART blocks.
package uart_pkg;

  localparam int OVERSAMPLE = 16;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit.
// Reset value is a parameter so idle-high lines come up inactive.
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver with optional parity.
// Samples each bit mid-period using a 16x tick supplied externally.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DBIT       = 8,
  parameter int SB_TICK    = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            s_tick,
  input  logic            rx,
  output logic [DBIT-1:0] dout,
  output logic            rx_done_tick,
  output logic            frame_err,
  output logic            parity_err
);

  localparam int SW = (SB_TICK > OVERSAMPLE) ?
                      $clog2(SB_TICK) : $clog2(OVERSAMPLE);

  localparam logic [SW-1:0] S_MID  = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] S_BIT  = SW'(OVERSAMPLE - 1);
  localparam logic [SW-1:0] S_STOP = SW'(SB_TICK - 1);
  localparam logic [2:0]    N_LAST = 3'(DBIT - 1);
  localparam logic          ODD    = 1'(PARITY_ODD);

  rx_state_t       state_q, state_d;
  logic [SW-1:0]   s_q, s_d;
  logic [2:0]      n_q, n_d;
  logic [DBIT-1:0] b_q, b_d;
  logic [DBIT-1:0] dout_q, dout_d;
  logic            pacc_q, pacc_d;
  logic            fe_q, fe_d;
  logic            pe_q, pe_d;
  logic            done_q, done_d;
  logic            rx_s;

  sync_2ff #(.RST_VAL(1'b1)) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (rx),
    .q       (rx_s)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      s_q     <= '0;
      n_q     <= '0;
      b_q     <= '0;
      dout_q  <= '0;
      pacc_q  <= 1'b0;
      fe_q    <= 1'b0;
      pe_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      n_q     <= n_d;
      b_q     <= b_d;
      dout_q  <= dout_d;
      pacc_q  <= pacc_d;
      fe_q    <= fe_d;
      pe_q    <= pe_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    b_d     = b_q;
    dout_d  = dout_q;
    pacc_d  = pacc_q;
    fe_d    = fe_q;
    pe_d    = pe_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        // Start detection is not gated by s_tick.
        if (!rx_s) begin
          state_d = START;
          s_d     = '0;
        end
      end
      START: begin
        if (s_tick) begin
          if (s_q == S_MID) begin
            if (rx_s) begin
              state_d = IDLE;
            end else begin
              state_d = DATA;
              s_d     = '0;
              n_d     = '0;
            end
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (s_q == S_BIT) begin
            s_d = '0;
            b_d = {rx_s, b_q[DBIT-1:1]};
            n_d = n_q + 3'd1;
            if (n_q == N_LAST) begin
              state_d = (PARITY_EN != 0) ? PARITY : STOP;
            end
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end
      PARITY: begin
        if (s_tick) begin
          if (s_q == S_BIT) begin
            pacc_d  = (^b_q) ^ rx_s ^ ODD;
            s_d     = '0;
            state_d = STOP;
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end
      STOP: begin
        if (s_tick) begin
          if (s_q == S_STOP) begin
            state_d = IDLE;
            dout_d  = b_q;
            fe_d    = ~rx_s;
            pe_d    = (PARITY_EN != 0) && pacc_q;
            done_d  = 1'b1;
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    dout         = dout_q;
    rx_done_tick = done_q;
    frame_err    = fe_q;
    parity_err   = pe_q;
  end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: 8N1, 8O1 and 5-bit/2-stop instances.
// Stimulus pushes expected words; monitors pop on rx_done_tick.
module tb_uart_rx;
  import uart_pkg::*;

  typedef struct packed {
    logic [7:0] d;
    logic       fe;
    logic       pe;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       s_tick = 1'b0;
  logic       rx_a = 1'b1;
  logic       rx_b = 1'b1;
  logic       rx_c = 1'b1;
  logic [7:0] dout_a, dout_b;
  logic [4:0] dout_c;
  logic       done_a, done_b, done_c;
  logic       fe_a, fe_b, fe_c;
  logic       pe_a, pe_b, pe_c;
  logic       pa = 1'b0, pb = 1'b0, pc = 1'b0;
  int         tcnt = 0;
  int         checks = 0;
  int         errors = 0;
  exp_t       qa[$], qb[$], qc[$];

  uart_rx u_a (
    .clk(clk), .reset_n(reset_n), .s_tick(s_tick), .rx(rx_a),
    .dout(dout_a), .rx_done_tick(done_a),
    .frame_err(fe_a), .parity_err(pe_a)
  );

  uart_rx #(.DBIT(8), .SB_TICK(16), .PARITY_EN(1), .PARITY_ODD(1)) u_b (
    .clk(clk), .reset_n(reset_n), .s_tick(s_tick), .rx(rx_b),
    .dout(dout_b), .rx_done_tick(done_b),
    .frame_err(fe_b), .parity_err(pe_b)
  );

  uart_rx #(.DBIT(5), .SB_TICK(32)) u_c (
    .clk(clk), .reset_n(reset_n), .s_tick(s_tick), .rx(rx_c),
    .dout(dout_c), .rx_done_tick(done_c),
    .frame_err(fe_c), .parity_err(pe_c)
  );

  always #5 clk = ~clk;

  // One tick every 4 clocks, changed on the falling edge.
  always @(negedge clk) begin
    tcnt   <= (tcnt == 3) ? 0 : tcnt + 1;
    s_tick <= (tcnt == 3);
  end

  task automatic chk(string n, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, got, exp);
    end
  endtask

  task automatic spurious(string n);
    checks++;
    errors++;
    $display("FAIL %s_unexpected_done: got done with empty queue, expected none", n);
  endtask

  task automatic cmp(string n, logic [7:0] d, logic fe, logic pe,
                     logic prev, exp_t e);
    chk({n, "_dout"}, 32'(d), 32'(e.d));
    chk({n, "_frame_err"}, 32'(fe), 32'(e.fe));
    chk({n, "_parity_err"}, 32'(pe), 32'(e.pe));
    chk({n, "_done_width"}, 32'(prev), 32'h0);
  endtask

  always @(negedge clk) begin
    if (done_a) begin
      if (qa.size() == 0) spurious("a");
      else cmp("a", dout_a, fe_a, pe_a, pa, qa.pop_front());
    end
    pa <= done_a;
  end

  always @(negedge clk) begin
    if (done_b) begin
      if (qb.size() == 0) spurious("b");
      else cmp("b", dout_b, fe_b, pe_b, pb, qb.pop_front());
    end
    pb <= done_b;
  end

  always @(negedge clk) begin
    if (done_c) begin
      if (qc.size() == 0) spurious("c");
      else cmp("c", {3'b000, dout_c}, fe_c, pe_c, pc, qc.pop_front());
    end
    pc <= done_c;
  end

  task automatic drv(int sel, logic v);
    @(negedge clk);
    case (sel)
      0:       rx_a = v;
      1:       rx_b = v;
      default: rx_c = v;
    endcase
  endtask

  task automatic ticks(int k);
    repeat (k) begin
      @(posedge clk);
      while (!s_tick) @(posedge clk);
    end
  endtask

  // par < 0 means no parity bit; st is stop-bit length in ticks.
  task automatic send(int sel, logic [7:0] d, int nb, int par,
                      logic stopv, int st);
    drv(sel, 1'b0);
    ticks(16);
    for (int i = 0; i < nb; i++) begin
      drv(sel, d[i]);
      ticks(16);
    end
    if (par >= 0) begin
      drv(sel, par[0]);
      ticks(16);
    end
    drv(sel, stopv);
    ticks(st);
    drv(sel, 1'b1);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    repeat (5) @(negedge clk);
    chk("rst_dout", 32'(dout_a), 32'h0);
    chk("rst_done", 32'(done_a), 32'h0);
    chk("rst_frame_err", 32'(fe_a), 32'h0);
    chk("rst_parity_err", 32'(pe_a), 32'h0);
    chk("rst_state", 32'(u_a.state_q), 32'(IDLE));
    chk("rst_sync", 32'(u_a.rx_s), 32'h1);
    reset_n = 1'b1;
    ticks(4);

    qa.push_back('{d: 8'h55, fe: 1'b0, pe: 1'b0});
    send(0, 8'h55, 8, -1, 1'b1, 16);
    ticks(8);

    // Short low pulse must be rejected at mid start bit.
    drv(0, 1'b0);
    ticks(4);
    drv(0, 1'b1);
    ticks(20);
    chk("glitch_idle", 32'(u_a.state_q), 32'(IDLE));

    qa.push_back('{d: 8'hA3, fe: 1'b0, pe: 1'b0});
    send(0, 8'hA3, 8, -1, 1'b1, 16);
    ticks(8);

    qa.push_back('{d: 8'h0F, fe: 1'b1, pe: 1'b0});
    send(0, 8'h0F, 8, -1, 1'b0, 12);
    ticks(24);

    qb.push_back('{d: 8'h01, fe: 1'b0, pe: 1'b1});
    send(1, 8'h01, 8, 1, 1'b1, 16);
    ticks(8);
    qb.push_back('{d: 8'h01, fe: 1'b0, pe: 1'b0});
    send(1, 8'h01, 8, 0, 1'b1, 16);
    ticks(8);

    qc.push_back('{d: 8'h13, fe: 1'b0, pe: 1'b0});
    send(2, 8'h13, 5, -1, 1'b1, 32);
    ticks(8);

    // Frame 0xFF interrupted by reset in the middle of bit 3.
    drv(0, 1'b0);
    ticks(16);
    drv(0, 1'b1);
    ticks(56);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("midrst_dout_a", 32'(dout_a), 32'h0);
    chk("midrst_frame_err_a", 32'(fe_a), 32'h0);
    chk("midrst_done_a", 32'(done_a), 32'h0);
    chk("midrst_dout_b", 32'(dout_b), 32'h0);
    chk("midrst_dout_c", 32'(dout_c), 32'h0);
    chk("midrst_state_a", 32'(u_a.state_q), 32'(IDLE));
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    ticks(120);

    qa.push_back('{d: 8'h3C, fe: 1'b0, pe: 1'b0});
    send(0, 8'h3C, 8, -1, 1'b1, 16);
    ticks(8);

    qa.push_back('{d: 8'h12, fe: 1'b0, pe: 1'b0});
    qa.push_back('{d: 8'h34, fe: 1'b0, pe: 1'b0});
    send(0, 8'h12, 8, -1, 1'b1, 16);
    send(0, 8'h34, 8, -1, 1'b1, 16);
    ticks(8);

    for (int i = 0; i < 2000; i++) begin
      if (qa.size() == 0 && qb.size() == 0 && qc.size() == 0) break;
      @(negedge clk);
    end
    chk("drain_a", 32'(qa.size()), 32'h0);
    chk("drain_b", 32'(qb.size()), 32'h0);
    chk("drain_c", 32'(qc.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
